prog_clock_divider: RTL and testbench

PROG_CLOCK_DIVIDER -- requirements
Module: prog_clock_divider

---
 rtl/prog_clock_divider_pkg.sv | 10 +
 rtl/clk_div_chan.sv | 90 +++++++++
 rtl/prog_clock_divider.sv | 48 ++++
 tb/tb_prog_clock_divider.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/prog_clock_divider_pkg.sv
// Shared constants for the programmable clock divider: reset defaults,
// the shortest legal period and the width of the channel index.
package prog_clock_divider_pkg;

  localparam int unsigned CFG_DEFAULT_DIV  = 100_000;
  localparam int unsigned CFG_DEFAULT_HIGH = 50_000;
  localparam int unsigned MIN_DIV          = 2;
  localparam int unsigned CH_IDX_W         = 4;

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: period counter, shadow configuration with clamping,
// boundary-only reload and registered clk_out/tick.
module clk_div_chan
  import prog_clock_divider_pkg::*;
#(
  parameter int unsigned WIDTH        = 32,
  parameter int unsigned DEFAULT_DIV  = CFG_DEFAULT_DIV,
  parameter int unsigned DEFAULT_HIGH = CFG_DEFAULT_HIGH
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic             i_wr,
  input  logic [WIDTH-1:0] i_wr_div,
  input  logic [WIDTH-1:0] i_wr_high,
  output logic             o_clk_out,
  output logic             o_tick,
  output logic             o_pending
);

  localparam int unsigned RST_DIV  = (DEFAULT_DIV < MIN_DIV) ? MIN_DIV : DEFAULT_DIV;
  localparam int unsigned RST_HIGH = (DEFAULT_HIGH == 0) ? 1 :
                                     (DEFAULT_HIGH >= RST_DIV) ? RST_DIV - 1 : DEFAULT_HIGH;

  logic [WIDTH-1:0] r_cnt;
  logic [WIDTH-1:0] r_div;
  logic [WIDTH-1:0] r_high;
  logic [WIDTH-1:0] r_shDiv;
  logic [WIDTH-1:0] r_shHigh;
  logic             r_pending;
  logic             r_clkOut;
  logic             r_tick;

  logic [WIDTH-1:0] w_clampDiv;
  logic [WIDTH-1:0] w_clampHigh;
  logic             w_last;
  logic             w_high;

  // High time is clamped against the already-clamped period.
  always_comb begin
    w_clampDiv = i_wr_div;
    if (i_wr_div < WIDTH'(MIN_DIV)) w_clampDiv = WIDTH'(MIN_DIV);
    w_clampHigh = i_wr_high;
    if (i_wr_high == '0) w_clampHigh = WIDTH'(1);
    else if (i_wr_high >= w_clampDiv) w_clampHigh = w_clampDiv - WIDTH'(1);
  end

  assign w_last = (r_cnt == r_div - WIDTH'(1));
  assign w_high = (r_cnt >= r_div - r_high);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt     <= '0;
      r_div     <= WIDTH'(RST_DIV);
      r_high    <= WIDTH'(RST_HIGH);
      r_shDiv   <= WIDTH'(RST_DIV);
      r_shHigh  <= WIDTH'(RST_HIGH);
      r_pending <= 1'b0;
      r_clkOut  <= 1'b0;
      r_tick    <= 1'b0;
    end else begin
      if (i_en) begin
        r_cnt    <= w_last ? '0 : r_cnt + WIDTH'(1);
        r_clkOut <= w_high;
        r_tick   <= w_last;
      end else begin
        r_cnt    <= '0;
        r_clkOut <= 1'b0;
        r_tick   <= 1'b0;
      end
      // Reload uses the shadow as it stood before this edge, so a write landing
      // on the wrap cycle waits for the following wrap.
      if (r_pending && (!i_en || w_last)) begin
        r_div     <= r_shDiv;
        r_high    <= r_shHigh;
        r_pending <= 1'b0;
      end
      if (i_wr) begin
        r_shDiv   <= w_clampDiv;
        r_shHigh  <= w_clampHigh;
        r_pending <= 1'b1;
      end
    end
  end

  assign o_clk_out = r_clkOut;
  assign o_tick    = r_tick;
  assign o_pending = r_pending;

endmodule

// File: rtl/prog_clock_divider.sv
// Multi-channel programmable clock divider: decodes configuration writes and
// fans them out to one independent clk_div_chan per channel.
module prog_clock_divider
  import prog_clock_divider_pkg::*;
#(
  parameter int unsigned NCH          = 4,
  parameter int unsigned WIDTH        = 32,
  parameter int unsigned DEFAULT_DIV  = CFG_DEFAULT_DIV,
  parameter int unsigned DEFAULT_HIGH = CFG_DEFAULT_HIGH
) (
  input  logic                clk_in,
  input  logic                rst,
  input  logic [NCH-1:0]      en,
  input  logic                cfg_wr,
  input  logic [CH_IDX_W-1:0] cfg_ch,
  input  logic [WIDTH-1:0]    cfg_div,
  input  logic [WIDTH-1:0]    cfg_high,
  output logic [NCH-1:0]      clk_out,
  output logic [NCH-1:0]      tick,
  output logic [NCH-1:0]      pending
);

  logic [NCH-1:0] w_wr;

  generate
    for (genvar g = 0; g < NCH; g++) begin : g_chan
      // Indices at or above NCH match no channel, so such writes vanish.
      assign w_wr[g] = cfg_wr && (cfg_ch == CH_IDX_W'(g));

      clk_div_chan #(
        .WIDTH        (WIDTH),
        .DEFAULT_DIV  (DEFAULT_DIV),
        .DEFAULT_HIGH (DEFAULT_HIGH)
      ) u_chan (
        .i_clk     (clk_in),
        .i_rst     (rst),
        .i_en      (en[g]),
        .i_wr      (w_wr[g]),
        .i_wr_div  (cfg_div),
        .i_wr_high (cfg_high),
        .o_clk_out (clk_out[g]),
        .o_tick    (tick[g]),
        .o_pending (pending[g])
      );
    end
  endgenerate

endmodule

// File: tb/tb_prog_clock_divider.sv
// Scoreboard bench: the driver advances a waveform-list reference model each
// cycle and queues the expected outputs; a monitor pops and compares them.
module tb_prog_clock_divider;

  localparam int NCH   = 4;
  localparam int WIDTH = 16;
  localparam int DDIV  = 7;
  localparam int DHIGH = 9;

  typedef struct packed {
    logic [NCH-1:0] clk;
    logic [NCH-1:0] tick;
    logic [NCH-1:0] pend;
  } exp_t;

  logic             clk_in = 1'b0;
  logic             rst    = 1'b1;
  logic [NCH-1:0]   en     = '0;
  logic             cfg_wr = 1'b0;
  logic [3:0]       cfg_ch = '0;
  logic [WIDTH-1:0] cfg_div  = '0;
  logic [WIDTH-1:0] cfg_high = '0;
  logic [NCH-1:0]   clk_out;
  logic [NCH-1:0]   tick;
  logic [NCH-1:0]   pending;

  int   nCompared   = 0;
  int   nMismatched = 0;
  exp_t expQ[$];

  int         mActP[NCH];
  int         mActH[NCH];
  int         mShP[NCH];
  int         mShH[NCH];
  bit         mPend[NCH];
  logic [1:0] wave[NCH][$];

  prog_clock_divider #(
    .NCH          (NCH),
    .WIDTH        (WIDTH),
    .DEFAULT_DIV  (DDIV),
    .DEFAULT_HIGH (DHIGH)
  ) dut (
    .clk_in   (clk_in),
    .rst      (rst),
    .en       (en),
    .cfg_wr   (cfg_wr),
    .cfg_ch   (cfg_ch),
    .cfg_div  (cfg_div),
    .cfg_high (cfg_high),
    .clk_out  (clk_out),
    .tick     (tick),
    .pending  (pending)
  );

  always #5 clk_in = ~clk_in;

  function automatic int clampP(input int d);
    return (d < 2) ? 2 : d;
  endfunction

  function automatic int clampH(input int p, input int h);
    int r;
    r = (h < 1) ? 1 : h;
    if (r > p - 1) r = p - 1;
    return r;
  endfunction

  task automatic modelReset();
    for (int i = 0; i < NCH; i++) begin
      mActP[i] = clampP(DDIV);
      mActH[i] = clampH(mActP[i], DHIGH);
      mShP[i]  = mActP[i];
      mShH[i]  = mActH[i];
      mPend[i] = 1'b0;
      wave[i].delete();
    end
  endtask

  // One period as an explicit list: low run, high run, tick on the last sample.
  task automatic fillPeriod(input int i);
    repeat (mActP[i] - mActH[i]) wave[i].push_back(2'b00);
    repeat (mActH[i] - 1) wave[i].push_back(2'b10);
    wave[i].push_back(2'b11);
  endtask

  task automatic modelEdge(input logic [NCH-1:0] e, input logic w, input int c,
                           input int d, input int h, output exp_t ex);
    bit wasPend;
    bit wrap;
    for (int i = 0; i < NCH; i++) begin
      wasPend = mPend[i];
      wrap    = 1'b0;
      if (e[i]) begin
        if (wave[i].size() == 0) fillPeriod(i);
        wrap = (wave[i].size() == 1);
        {ex.clk[i], ex.tick[i]} = wave[i].pop_front();
      end else begin
        wave[i].delete();
        ex.clk[i]  = 1'b0;
        ex.tick[i] = 1'b0;
      end
      if (wasPend && (!e[i] || wrap)) begin
        mActP[i] = mShP[i];
        mActH[i] = mShH[i];
        mPend[i] = 1'b0;
      end
      if (w && c == i) begin
        mShP[i]  = clampP(d);
        mShH[i]  = clampH(mShP[i], h);
        mPend[i] = 1'b1;
      end
      ex.pend[i] = mPend[i];
    end
  endtask

  task automatic checkOutput(input string name, input logic [NCH-1:0] act,
                             input logic [NCH-1:0] req);
    nCompared++;
    if (act !== req) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %b required %b at %0t", name, act, req, $time);
    end
  endtask

  task automatic applyStimulus(input logic [NCH-1:0] e, input logic w, input int c,
                               input int d, input int h);
    exp_t ex;
    @(negedge clk_in);
    en       = e;
    cfg_wr   = w;
    cfg_ch   = 4'(c);
    cfg_div  = WIDTH'(d);
    cfg_high = WIDTH'(h);
    modelEdge(e, w, c, d, h, ex);
    expQ.push_back(ex);
  endtask

  task automatic runIdle(input int n, input logic [NCH-1:0] e);
    repeat (n) applyStimulus(e, 1'b0, 0, 0, 0);
  endtask

  // Short asynchronous pulse between edges; outputs must drop at once.
  task automatic resetPulse();
    exp_t ex;
    @(negedge clk_in);
    cfg_wr = 1'b0;
    #1 rst = 1'b1;
    #1;
    checkOutput("rst_clk_out", clk_out, '0);
    checkOutput("rst_tick", tick, '0);
    checkOutput("rst_pending", pending, '0);
    rst = 1'b0;
    modelReset();
    modelEdge(en, 1'b0, 0, 0, 0, ex);
    expQ.push_back(ex);
  endtask

  initial begin : monitor
    exp_t ex;
    forever begin
      @(posedge clk_in);
      #1;
      if (expQ.size() > 0) begin
        ex = expQ.pop_front();
        checkOutput("clk_out", clk_out, ex.clk);
        checkOutput("tick", tick, ex.tick);
        checkOutput("pending", pending, ex.pend);
      end
    end
  end

  initial begin : driver
    logic [NCH-1:0] eVec;
    modelReset();
    repeat (3) @(negedge clk_in);
    checkOutput("init_clk_out", clk_out, '0);
    checkOutput("init_tick", tick, '0);
    checkOutput("init_pending", pending, '0);
    rst = 1'b0;

    $display("[TB] basic 4-cycle period on ch0");
    applyStimulus(4'b0000, 1'b1, 0, 4, 2);
    runIdle(1, 4'b0000);
    runIdle(12, 4'b0001);

    $display("[TB] clamping of period and high time");
    applyStimulus(4'b0001, 1'b1, 0, 1, 0);
    runIdle(10, 4'b0001);
    applyStimulus(4'b0001, 1'b1, 0, 5, 9);
    runIdle(14, 4'b0001);

    $display("[TB] mid-period reconfiguration of ch1");
    applyStimulus(4'b0001, 1'b1, 1, 10, 5);
    runIdle(2, 4'b0001);
    runIdle(3, 4'b0011);
    applyStimulus(4'b0011, 1'b1, 1, 4, 2);
    runIdle(20, 4'b0011);

    $display("[TB] writes around the wrap and to an absent channel");
    for (int k = 0; k < 4; k++) begin
      applyStimulus(4'b0011, 1'b1, 1, (k % 2 == 0) ? 6 : 4, 3);
      runIdle(k + 3, 4'b0011);
    end
    applyStimulus(4'b0011, 1'b1, 15, 3, 1);
    runIdle(16, 4'b0011);

    $display("[TB] asynchronous reset mid-period");
    runIdle(3, 4'b1111);
    applyStimulus(4'b1111, 1'b1, 3, 3, 1);
    resetPulse();
    runIdle(16, 4'b1111);

    $display("[TB] disable and re-enable ch2");
    runIdle(4, 4'b1111);
    runIdle(4, 4'b1011);
    runIdle(15, 4'b1111);

    $display("[TB] randomized traffic");
    eVec = 4'b1111;
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 15) == 0) eVec[$urandom_range(0, NCH - 1)] ^= 1'b1;
      if ($urandom_range(0, 249) == 0) resetPulse();
      else if ($urandom_range(0, 5) == 0)
        applyStimulus(eVec, 1'b1, $urandom_range(0, 15), $urandom_range(0, 12),
                      $urandom_range(0, 14));
      else
        applyStimulus(eVec, 1'b0, 0, 0, 0);
    end

    @(posedge clk_in);
    #2;
    if (expQ.size() != 0) begin
      nCompared++;
      nMismatched++;
      $display("[TB] FAIL drain: %0d entries left, required 0", expQ.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
